// File: rtl/multi_ported_sram_pkg.sv
// Shared definitions for the LVT-based multi-ported memory.
//   calc_aw       : address width for an N-entry array (at least 1 bit)
//   calc_lw       : width of a live-value-table entry for NUM_W banks (at least 1 bit)
//   bypass_mode_e : read-during-write behaviour selected by the BYPASS parameter
package multi_ported_sram_pkg;

  typedef enum logic {
    BYPASS_READ_FIRST  = 1'b0,  // same-cycle read returns the pre-write value
    BYPASS_WRITE_FIRST = 1'b1   // same-cycle read returns the winning write data
  } bypass_mode_e;

  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int calc_lw(input int num_w);
    return (num_w > 1) ? $clog2(num_w) : 1;
  endfunction

endpackage

// File: rtl/mp_lvt_table.sv
// Live Value Table: one LW-bit entry per memory address naming the bank that
// holds the most recent value for that address.
//   clk, rst : clock and synchronous active-high reset (all entries -> 0)
//   we       : per-port write enable, arbitration already applied, so no two
//              asserted ports share an address
//   waddr    : write address, port j at [j*AW +: AW]
//   raddr    : read address, port i at [i*AW +: AW]
//   rsel     : combinational bank index for read port i at [i*LW +: LW]
module mp_lvt_table
  import multi_ported_sram_pkg::*;
#(
  parameter int N     = 1024,
  parameter int NUM_W = 3,
  parameter int NUM_R = 3,
  parameter int AW    = calc_aw(N),
  parameter int LW    = calc_lw(NUM_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_W-1:0]    we,
  input  logic [NUM_W*AW-1:0] waddr,
  input  logic [NUM_R*AW-1:0] raddr,
  output logic [NUM_R*LW-1:0] rsel
);

  logic [LW-1:0] lvt [N];

  // Writes never overlap in address, so loop order does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < N; e++) lvt[e] <= '0;
    end else begin
      for (int j = 0; j < NUM_W; j++) begin
        if (we[j]) lvt[waddr[j*AW +: AW]] <= LW'(j);
      end
    end
  end

  always_comb begin
    rsel = '0;
    for (int i = 0; i < NUM_R; i++) begin
      rsel[i*LW +: LW] = lvt[raddr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/multi_ported_lvt_mem.sv
// NUM_R-read / NUM_W-write memory built from NUM_W replicated 1W/NUM_R-read
// flop banks plus a Live Value Table that records which bank is current.
//   clk, rst : clock, synchronous active-high reset
//   ren      : per-port read request, raddr port i at [i*AW +: AW]
//   rvalid   : rdata for port i is valid this cycle (one cycle after ren)
//   rdata    : read data, port i at [i*W +: W]; holds when no read issued
//   wen      : per-port write request, waddr/wdata port j at [j*AW]/[j*W]
//   wcollide : one-cycle pulse, port j's write was dropped last cycle
//   coll_cnt : saturating count of cycles that dropped at least one write
// Handshake: there is no ready/backpressure. Every ren is accepted and is
// answered exactly one cycle later by rvalid; rvalid is never asserted
// without a matching ren on the previous edge (and never after a reset cycle).
// Every wen is accepted; it either takes effect or is reported via wcollide.
module multi_ported_lvt_mem
  import multi_ported_sram_pkg::*;
#(
  parameter  int NUM_R  = 3,
  parameter  int NUM_W  = 3,
  parameter  int W      = 32,
  parameter  int N      = 1024,
  parameter  int BYPASS = 1,
  parameter  int CNT_W  = 16,
  localparam int AW     = calc_aw(N),
  localparam int LW     = calc_lw(NUM_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_R-1:0]    ren,
  input  logic [NUM_R*AW-1:0] raddr,
  output logic [NUM_R-1:0]    rvalid,
  output logic [NUM_R*W-1:0]  rdata,
  input  logic [NUM_W-1:0]    wen,
  input  logic [NUM_W*AW-1:0] waddr,
  input  logic [NUM_W*W-1:0]  wdata,
  output logic [NUM_W-1:0]    wcollide,
  output logic [CNT_W-1:0]    coll_cnt
);

  logic [NUM_W-1:0]    win;
  logic [NUM_W-1:0]    lose;
  logic [NUM_W-1:0]    bank_we;
  logic [NUM_R*LW-1:0] lvt_sel;
  logic [W-1:0]        bank_rd [NUM_W][NUM_R];
  logic [NUM_R*W-1:0]  rd_next;

  // A write wins unless some higher-indexed port writes the same address.
  // This one mask drives bank enables, LVT enables, bypass and collisions.
  always_comb begin
    win = wen;
    for (int j = 0; j < NUM_W; j++) begin
      for (int k = j + 1; k < NUM_W; k++) begin
        if (wen[k] && (waddr[k*AW +: AW] == waddr[j*AW +: AW])) win[j] = 1'b0;
      end
    end
  end

  assign lose    = wen & ~win;
  assign bank_we = rst ? '0 : win;

  // Bank j is only ever written by write port j; contents are not reset.
  for (genvar j = 0; j < NUM_W; j++) begin : g_bank
    logic [W-1:0] mem [N];

    always_ff @(posedge clk) begin
      if (bank_we[j]) mem[waddr[j*AW +: AW]] <= wdata[j*W +: W];
    end

    for (genvar i = 0; i < NUM_R; i++) begin : g_rd
      assign bank_rd[j][i] = mem[raddr[i*AW +: AW]];
    end
  end

  mp_lvt_table #(
    .N     (N),
    .NUM_W (NUM_W),
    .NUM_R (NUM_R),
    .AW    (AW),
    .LW    (LW)
  ) u_lvt (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we),
    .waddr (waddr),
    .raddr (raddr),
    .rsel  (lvt_sel)
  );

  // Pick the live bank per read port; in write-first mode a winning write to
  // the same address overrides it. Winners have unique addresses, so at most
  // one forwarding source matches.
  always_comb begin
    rd_next = '0;
    for (int i = 0; i < NUM_R; i++) begin
      for (int j = 0; j < NUM_W; j++) begin
        if (lvt_sel[i*LW +: LW] == LW'(j)) rd_next[i*W +: W] = bank_rd[j][i];
      end
      if (BYPASS == int'(BYPASS_WRITE_FIRST)) begin
        for (int j = 0; j < NUM_W; j++) begin
          if (win[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
            rd_next[i*W +: W] = wdata[j*W +: W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid   <= '0;
      rdata    <= '0;
      wcollide <= '0;
      coll_cnt <= '0;
    end else begin
      rvalid   <= ren;
      wcollide <= lose;
      for (int i = 0; i < NUM_R; i++) begin
        if (ren[i]) rdata[i*W +: W] <= rd_next[i*W +: W];
      end
      if ((|lose) && (coll_cnt != {CNT_W{1'b1}})) coll_cnt <= coll_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_ported_lvt_mem.sv
module tb_multi_ported_lvt_mem;

  // Instance A: default build (3R3W, 32b, 1024 entries, write-first).
  // Instance B: 4R2W, 16b, 64 entries, read-first, 2-bit counter.
  // Instance C: 1R1W degenerate build.
  localparam int B_N = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rst;
  logic [2:0]  a_ren, a_rvalid, a_wen, a_wcollide;
  logic [29:0] a_raddr, a_waddr;
  logic [95:0] a_rdata, a_wdata;
  logic [15:0] a_coll_cnt;

  logic        b_rst;
  logic [3:0]  b_ren, b_rvalid;
  logic [23:0] b_raddr;
  logic [63:0] b_rdata;
  logic [1:0]  b_wen, b_wcollide, b_coll_cnt;
  logic [11:0] b_waddr;
  logic [31:0] b_wdata;

  logic        c_rst;
  logic [0:0]  c_ren, c_rvalid, c_wen, c_wcollide;
  logic [3:0]  c_raddr, c_waddr;
  logic [7:0]  c_rdata, c_wdata;
  logic [15:0] c_coll_cnt;

  multi_ported_lvt_mem dut_a (
    .clk(clk), .rst(a_rst), .ren(a_ren), .raddr(a_raddr), .rvalid(a_rvalid),
    .rdata(a_rdata), .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata),
    .wcollide(a_wcollide), .coll_cnt(a_coll_cnt)
  );

  multi_ported_lvt_mem #(
    .NUM_R(4), .NUM_W(2), .W(16), .N(B_N), .BYPASS(0), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(b_rst), .ren(b_ren), .raddr(b_raddr), .rvalid(b_rvalid),
    .rdata(b_rdata), .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata),
    .wcollide(b_wcollide), .coll_cnt(b_coll_cnt)
  );

  multi_ported_lvt_mem #(
    .NUM_R(1), .NUM_W(1), .W(8), .N(16), .BYPASS(1), .CNT_W(16)
  ) dut_c (
    .clk(clk), .rst(c_rst), .ren(c_ren), .raddr(c_raddr), .rvalid(c_rvalid),
    .rdata(c_rdata), .wen(c_wen), .waddr(c_waddr), .wdata(c_wdata),
    .wcollide(c_wcollide), .coll_cnt(c_coll_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- table-driven vectors for instance A ----------------
  typedef struct packed {
    logic             rst;
    logic [2:0]       ren;
    logic [2:0][9:0]  raddr;
    logic [2:0]       wen;
    logic [2:0][9:0]  waddr;
    logic [2:0][31:0] wdata;
    logic [2:0]       e_rvalid;
    logic [2:0]       chk;      // which rdata ports to compare
    logic [2:0][31:0] e_rdata;
    logic [2:0]       e_wcoll;
    logic [15:0]      e_cnt;
  } a_vec_t;

  a_vec_t a_vecs[$];

  task automatic add_a(input int rst, input int ren, input int ra0, input int ra1, input int ra2,
                       input int wen, input int wa0, input int wa1, input int wa2,
                       input logic [31:0] wd0, input logic [31:0] wd1, input logic [31:0] wd2,
                       input int ev, input int chk,
                       input logic [31:0] ed0, input logic [31:0] ed1, input logic [31:0] ed2,
                       input int ewc, input int ecnt);
    a_vec_t v;
    v.rst      = rst[0];
    v.ren      = ren[2:0];
    v.raddr    = {ra2[9:0], ra1[9:0], ra0[9:0]};
    v.wen      = wen[2:0];
    v.waddr    = {wa2[9:0], wa1[9:0], wa0[9:0]};
    v.wdata    = {wd2, wd1, wd0};
    v.e_rvalid = ev[2:0];
    v.chk      = chk[2:0];
    v.e_rdata  = {ed2, ed1, ed0};
    v.e_wcoll  = ewc[2:0];
    v.e_cnt    = ecnt[15:0];
    a_vecs.push_back(v);
  endtask

  // ---------------- reference model for instance B ----------------
  // The memory is seen as one value per address; a write takes effect unless
  // a higher port writes the same address in the same cycle.
  logic [15:0] m_mem [B_N];
  bit          m_known [B_N];
  logic [15:0] m_rd [4];
  bit          m_rd_known [4];
  int          m_cnt;
  logic [15:0] exp_q[$];

  initial begin
    a_vec_t v;
    logic [1:0] lost;
    logic [3:0] exp_rvalid;
    int ra, wa0, wa1;

    a_rst = 1'b1; a_ren = '0; a_raddr = '0; a_wen = '0; a_waddr = '0; a_wdata = '0;
    b_rst = 1'b1; b_ren = '0; b_raddr = '0; b_wen = '0; b_waddr = '0; b_wdata = '0;
    c_rst = 1'b1; c_ren = '0; c_raddr = '0; c_wen = '0; c_waddr = '0; c_wdata = '0;
    step();
    b_rst = 1'b0;
    c_rst = 1'b0;

    //     rst ren    ra0    ra1    ra2    wen    wa0    wa1    wa2    wd0          wd1      wd2      ev     chk    ed0          ed1          ed2          ewc    cnt
    add_a(1, 'b000, 0,     0,     0,     'b000, 0,     0,     0,     0,           0,       0,       'b000, 'b111, 0,           0,           0,           'b000, 0);
    add_a(0, 'b000, 0,     0,     0,     'b001, 'h10,  0,     0,     'hDEADBEEF,  0,       0,       'b000, 'b111, 0,           0,           0,           'b000, 0);
    add_a(0, 'b100, 0,     0,     'h10,  'b000, 0,     0,     0,     0,           0,       0,       'b100, 'b100, 0,           0,           'hDEADBEEF,  'b000, 0);
    add_a(0, 'b000, 0,     0,     0,     'b111, 'h3FF, 'h3FF, 'h3FF, 1,           2,       3,       'b000, 'b100, 0,           0,           'hDEADBEEF,  'b011, 1);
    add_a(0, 'b001, 'h3FF, 0,     0,     'b001, 'h50,  0,     0,     'h1234,      0,       0,       'b001, 'b001, 3,           0,           0,           'b000, 1);
    add_a(0, 'b000, 0,     0,     0,     'b001, 'h20,  0,     0,     'h11,        0,       0,       'b000, 'b101, 3,           0,           'hDEADBEEF,  'b000, 1);
    add_a(0, 'b001, 'h20,  0,     0,     'b010, 0,     'h20,  0,     0,           'h55,    0,       'b001, 'b001, 'h55,        0,           0,           'b000, 1);
    add_a(0, 'b100, 0,     0,     'h20,  'b011, 'h20,  'h20,  0,     'h66,        'h77,    0,       'b100, 'b101, 'h55,        0,           'h77,        'b001, 2);
    add_a(0, 'b010, 0,     'h20,  0,     'b000, 0,     0,     0,     0,           0,       0,       'b010, 'b011, 'h55,        'h77,        0,           'b000, 2);
    add_a(0, 'b000, 0,     0,     0,     'b010, 0,     'h40,  0,     0,           7,       0,       'b000, 'b000, 0,           0,           0,           'b000, 2);
    add_a(0, 'b000, 0,     0,     0,     'b100, 0,     0,     'h40,  0,           0,       9,       'b000, 'b000, 0,           0,           0,           'b000, 2);
    add_a(0, 'b011, 'h40,  'h10,  0,     'b000, 0,     0,     0,     0,           0,       0,       'b011, 'b011, 9,           'hDEADBEEF,  0,           'b000, 2);
    add_a(0, 'b111, 'h10,  'h3FF, 'h40,  'b000, 0,     0,     0,     0,           0,       0,       'b111, 'b111, 'hDEADBEEF,  3,           9,           'b000, 2);
    add_a(1, 'b111, 'h10,  'h3FF, 'h40,  'b011, 'h50,  'h50,  0,     'hBAD,       'hBEE,   0,       'b000, 'b111, 0,           0,           0,           'b000, 0);
    add_a(0, 'b011, 'h50,  'h10,  0,     'b000, 0,     0,     0,     0,           0,       0,       'b011, 'b111, 'h1234,      'hDEADBEEF,  0,           'b000, 0);

    for (int n = 0; n < a_vecs.size(); n++) begin
      v = a_vecs[n];
      a_rst = v.rst; a_ren = v.ren; a_raddr = v.raddr;
      a_wen = v.wen; a_waddr = v.waddr; a_wdata = v.wdata;
      step();
      check($sformatf("a%0d rvalid", n), 64'(a_rvalid), 64'(v.e_rvalid));
      check($sformatf("a%0d wcollide", n), 64'(a_wcollide), 64'(v.e_wcoll));
      check($sformatf("a%0d coll_cnt", n), 64'(a_coll_cnt), 64'(v.e_cnt));
      for (int i = 0; i < 3; i++) begin
        if (v.chk[i]) check($sformatf("a%0d rdata%0d", n, i), 64'(a_rdata[i*32 +: 32]), 64'(v.e_rdata[i]));
      end
    end
    a_rst = 1'b0; a_ren = '0; a_wen = '0;

    // ---------------- instance B: read-first and counter saturation ----------------
    b_wen = 2'b01; b_waddr = {6'h00, 6'h20}; b_wdata = {16'h0000, 16'h0011};
    step();
    b_wen = 2'b10; b_waddr = {6'h20, 6'h00}; b_wdata = {16'h0055, 16'h0000};
    b_ren = 4'b0001; b_raddr = {18'h0, 6'h20};
    step();
    check("b read-first rvalid", 64'(b_rvalid), 64'(4'b0001));
    check("b read-first rdata", 64'(b_rdata[15:0]), 64'(16'h0011));
    b_wen = '0;
    step();
    check("b after-write rdata", 64'(b_rdata[15:0]), 64'(16'h0055));
    b_ren = '0;
    b_wen = 2'b11; b_waddr = {6'h05, 6'h05}; b_wdata = {16'h0bbb, 16'h0aaa};
    for (int n = 0; n < 5; n++) begin
      step();
      check($sformatf("b sat cnt %0d", n), 64'(b_coll_cnt), 64'((n < 3) ? n + 1 : 3));
      check($sformatf("b sat wcollide %0d", n), 64'(b_wcollide), 64'(2'b01));
    end
    b_wen = '0;
    step();
    check("b wcollide pulse ends", 64'(b_wcollide), 64'(2'b00));
    check("b cnt holds", 64'(b_coll_cnt), 64'(3));
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    check("b reset cnt", 64'(b_coll_cnt), 64'(0));
    check("b reset rvalid", 64'(b_rvalid), 64'(0));

    // ---------------- instance B: random against the model ----------------
    for (int e = 0; e < B_N; e++) m_known[e] = 1'b0;
    for (int i = 0; i < 4; i++) begin m_rd[i] = '0; m_rd_known[i] = 1'b1; end
    m_cnt = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      b_rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 4; i++) begin
        b_ren[i] = 1'($urandom_range(0, 1));
        b_raddr[i*6 +: 6] = 6'(($urandom_range(0, 3) == 0) ? $urandom_range(0, B_N - 1) : $urandom_range(0, 7));
      end
      for (int j = 0; j < 2; j++) begin
        b_wen[j] = 1'($urandom_range(0, 1));
        b_waddr[j*6 +: 6] = 6'($urandom_range(0, 7));
        b_wdata[j*16 +: 16] = 16'($urandom);
      end
      wa0 = int'(b_waddr[5:0]);
      wa1 = int'(b_waddr[11:6]);
      lost = 2'b00;
      exp_rvalid = 4'b0000;
      if (b_rst) begin
        for (int e = 0; e < B_N; e++) m_known[e] = 1'b0;
        for (int i = 0; i < 4; i++) begin m_rd[i] = '0; m_rd_known[i] = 1'b1; end
        m_cnt = 0;
      end else begin
        if (b_wen[0] && b_wen[1] && (wa0 == wa1)) lost[0] = 1'b1;
        // Reads see memory before this cycle's writes.
        for (int i = 0; i < 4; i++) begin
          if (b_ren[i]) begin
            ra = int'(b_raddr[i*6 +: 6]);
            m_rd[i] = m_mem[ra];
            m_rd_known[i] = m_known[ra];
          end
        end
        exp_rvalid = b_ren;
        if (b_wen[0] && !lost[0]) begin m_mem[wa0] = b_wdata[15:0]; m_known[wa0] = 1'b1; end
        if (b_wen[1]) begin m_mem[wa1] = b_wdata[31:16]; m_known[wa1] = 1'b1; end
        if ((lost != 2'b00) && (m_cnt < 3)) m_cnt++;
      end
      for (int i = 0; i < 4; i++) begin
        if (m_rd_known[i]) exp_q.push_back(m_rd[i]);
      end
      step();
      check($sformatf("rnd%0d rvalid", cyc), 64'(b_rvalid), 64'(exp_rvalid));
      check($sformatf("rnd%0d wcollide", cyc), 64'(b_wcollide), 64'(lost));
      check($sformatf("rnd%0d coll_cnt", cyc), 64'(b_coll_cnt), 64'(m_cnt));
      for (int i = 0; i < 4; i++) begin
        if (m_rd_known[i]) check($sformatf("rnd%0d rdata%0d", cyc, i), 64'(b_rdata[i*16 +: 16]), 64'(exp_q.pop_front()));
      end
    end
    b_rst = 1'b0; b_ren = '0; b_wen = '0;

    // ---------------- instance C: single write port ----------------
    c_wen = 1'b1; c_waddr = 4'h3; c_wdata = 8'hA5; c_ren = 1'b1; c_raddr = 4'h3;
    step();
    check("c bypass rdata", 64'(c_rdata), 64'(8'hA5));
    check("c rvalid", 64'(c_rvalid), 64'(1));
    check("c wcollide", 64'(c_wcollide), 64'(0));
    c_wen = 1'b0;
    step();
    check("c reread rdata", 64'(c_rdata), 64'(8'hA5));
    check("c coll_cnt", 64'(c_coll_cnt), 64'(0));
    c_ren = 1'b0;
    step();
    check("c rvalid drop", 64'(c_rvalid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
